// File: rtl/fp_mul_arbiter_if.sv
// Request/result bus between the ALU front-end ports and the shared FP multiplier arbiter.
// The arbiter is the slave; requesters and the result consumer form the master side.
interface fp_mul_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][31:0] req_a;
  logic [NUM_REQ-1:0][31:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [31:0]              res_product;
  logic [ID_W-1:0]          res_id;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_product, res_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_product, res_id, busy
  );
endinterface

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational IEEE-754 single-precision multiplier
// among NUM_REQ requesters; results are returned tagged with the requester index.

module fp_mul_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);
  function automatic logic [5:0] lzc48(input logic [47:0] v);
    lzc48 = 6'd48;
    for (int i = 0; i < 48; i++)
      if (v[i]) lzc48 = 6'(47 - i);
  endfunction

  logic              sgn;
  logic [7:0]        ea, eb, ea_eff, eb_eff;
  logic [22:0]       fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0]       prod, pn;
  logic [5:0]        lz, sh;
  logic signed [9:0] e_n, shs;
  logic [95:0]       ext;
  logic [7:0]        base_exp;
  logic [30:0]       mag, mag_r;
  logic              g, s, rnd;

  always_comb begin
    sgn    = a_i[31] ^ b_i[31];
    ea     = a_i[30:23];
    eb     = b_i[30:23];
    fa     = a_i[22:0];
    fb     = b_i[22:0];
    a_nan  = (ea == 8'hFF) && (fa != '0);
    b_nan  = (eb == 8'hFF) && (fb != '0);
    a_inf  = (ea == 8'hFF) && (fa == '0);
    b_inf  = (eb == 8'hFF) && (fb == '0);
    a_zero = (ea == 8'h00) && (fa == '0);
    b_zero = (eb == 8'h00) && (fb == '0);
    // Subnormals use exponent 1 with no hidden bit.
    ea_eff = (ea == 8'h00) ? 8'd1 : ea;
    eb_eff = (eb == 8'h00) ? 8'd1 : eb;
    prod   = {(ea != 8'h00), fa} * {(eb != 8'h00), fb};
    lz     = lzc48(prod);
    pn     = prod << lz;
    e_n    = $signed({2'b00, ea_eff}) + $signed({2'b00, eb_eff})
           - 10'sd126 - $signed({4'b0000, lz});
    shs    = 10'sd1 - e_n;
    if (e_n >= 10'sd1)      sh = 6'd0;
    else if (shs > 10'sd63) sh = 6'd63;
    else                    sh = shs[5:0];
    ext      = {pn, 48'd0} >> sh;
    // Hidden bit in ext[95] adds the final 1 to the exponent field for normals.
    base_exp = (e_n >= 10'sd1) ? 8'(e_n - 10'sd1) : 8'h00;
    mag      = {base_exp, 23'd0} + {7'd0, ext[95:72]};
    g        = ext[71];
    s        = |ext[70:0];
    rnd      = g & (s | mag[0]);
    mag_r    = mag + {30'd0, rnd};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      p_o = 32'h7FC0_0000;
    else if (a_inf || b_inf || (e_n >= 10'sd255))
      p_o = {sgn, 8'hFF, 23'd0};
    else if (a_zero || b_zero)
      p_o = {sgn, 31'd0};
    else
      p_o = {sgn, mag_r};
  end
endmodule

module fp_mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic           clk,
  input  logic           rst,
  fp_mul_arbiter_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
  logic [31:0]     prod_q, prod_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [ID_W-1:0] win;
  logic            found;
  logic [31:0]     mul_p;

  fp_mul_core u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // First valid bit at or after rr_q, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_q) + k) % NUM_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end
  end

  // Gated with rst so a request pending during reset is not shown as accepted.
  assign bus.req_ready   = (state_q == S_IDLE && found && !rst)
                           ? (NUM_REQ'(1) << win) : '0;
  assign bus.res_valid   = (state_q == S_DONE);
  assign bus.res_product = prod_q;
  assign bus.res_id      = id_q;
  assign bus.busy        = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    prod_d  = prod_q;
    id_d    = id_q;
    rr_d    = rr_q;
    case (state_q)
      S_IDLE: if (found) begin
        op_a_d  = bus.req_a[win];
        op_b_d  = bus.req_b[win];
        id_d    = win;
        rr_d    = (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
        state_d = S_EXEC;
      end
      S_EXEC: begin
        prod_d  = mul_p;
        state_d = S_DONE;
      end
      S_DONE: if (bus.res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      prod_q  <= '0;
      id_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      prod_q  <= prod_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(bus.req_ready));

  a_hold_result: assert property (@(posedge clk) disable iff (rst)
    (bus.res_valid && !bus.res_ready) |=>
      (bus.res_valid && $stable(bus.res_product) && $stable(bus.res_id)));
endmodule
